sys_ctrl_tx_sched: RTL and testbench
====================================

Name: sys_ctrl_tx_sched

Overview:
Transmit-side system controller. Collects responses from the register file (read data) and the ALU (result), arbitrates between them, and sequences them byte-by-byte into the UART transmitter over a level handshake. Sits between RegFile/ALU and UART_TX, alongside the receive-side controller. It is the only block that drives UART_TX parallel input.

Parameters:
DATA_WIDTH, 8, UART frame width and register-file data width.
ALU_OUT_WIDTH, 16, ALU result width. Fixed at 2*DATA_WIDTH and sent as two frames.

Ports:
CLK  in  1  system clock (REF domain)
RST  in  1  reset, asynchronous, active-low
RD_DATA  in  DATA_WIDTH  register-file read data
RD_DATA_VLD  in  1  one-cycle strobe, RD_DATA valid
ALU_OUT  in  ALU_OUT_WIDTH  ALU result
ALU_OUT_VLD  in  1  one-cycle strobe, ALU_OUT valid
TX_BUSY  in  1  UART_TX busy, already synchronised to CLK upstream
TX_P_DATA  out  DATA_WIDTH  byte to UART_TX
TX_D_VLD  out  1  request to UART_TX, level, held until acknowledged
CTRL_BUSY  out  1  high when any slot is pending or FSM not IDLE
OVERRUN  out  1  one-cycle pulse, a response was dropped

Behaviour:
- Reset (RST low, async): FSM=IDLE; both slots empty; TX_P_DATA=0, TX_D_VLD=0, OVERRUN=0, CTRL_BUSY=0. Mid-transfer reset aborts immediately, with no partial completion.
- All outputs are registered. CTRL_BUSY = (state!=IDLE) | rd_pend | alu_pend, registered.
- Pending slots (one per source):
  - On VLD with slot empty: capture data, set pend.
  - On VLD with slot full: drop new data, keep old, pulse OVERRUN next cycle.
  - A slot is cleared on the cycle the FSM leaves IDLE to serve it, so a new strobe may arrive during its transmission.
  - Clear and VLD in the same cycle: capture wins; pend stays 1 with new data.
- Arbitration in IDLE, taken only when TX_BUSY=0:
  - Fixed priority: RD over ALU.
  - Both pending → RD served first, ALU on next IDLE.
- FSM states: IDLE, RD_REQ, RD_WAIT, LO_REQ, LO_WAIT, HI_REQ, HI_WAIT.
  - IDLE → RD_REQ if rd_pend & !TX_BUSY; load TX_P_DATA=rd_buf, TX_D_VLD=1.
  - IDLE → LO_REQ if alu_pend & !rd_pend & !TX_BUSY; latch alu_buf into a 16-bit shadow; TX_P_DATA=shadow[7:0], TX_D_VLD=1.
  - x_REQ: hold TX_D_VLD and TX_P_DATA stable until TX_BUSY=1. Then TX_D_VLD←0 and go to x_WAIT.
  - RD_WAIT: on TX_BUSY=0 → IDLE.
  - LO_WAIT: on TX_BUSY=0 → HI_REQ; TX_P_DATA=shadow[15:8], TX_D_VLD=1.
  - HI_WAIT: on TX_BUSY=0 → IDLE.
- Byte order for ALU results: low byte first, then high byte.
- Minimum spacing: one IDLE cycle between consecutive responses.
- No timeout. The FSM waits indefinitely in REQ or WAIT states.
- TX_P_DATA holds its last value when TX_D_VLD=0.
- Illegal state encodings → IDLE next cycle, all outputs deasserted.

Decomposition:
- Package sys_ctrl_pkg holds:
  - FSM state encoding (3-bit localparams).
  - DATA_WIDTH default.
  - Byte-select constants LO=0, HI=1.
- One sub-module, tx_pend_slot: a parameterised-width capture register with pend flag, clear input and overrun pulse. Instantiated twice (WIDTH=DATA_WIDTH, WIDTH=ALU_OUT_WIDTH).

Test Plan:
1. RD_DATA=8'h5A strobe, TX_BUSY model asserts 2 cycles after TX_D_VLD and lasts 10 cycles → one frame 8'h5A; TX_D_VLD drops the cycle after TX_BUSY=1; FSM back to IDLE after TX_BUSY falls; CTRL_BUSY low afterwards.
2. ALU_OUT=16'hBEEF strobe → frames 8'hEF then 8'hBE, in that order, each with a full handshake; no third frame.
3. RD_DATA=8'h11 and ALU_OUT=16'h2233 strobed in the same cycle → frame order 8'h11, 8'h33, 8'h22.
4. ALU_OUT=16'h0102, then ALU_OUT=16'hAAAA while still pending (TX_BUSY held high from a prior frame) → OVERRUN pulses once; frames sent are 8'h02, 8'h01 only.
5. RD strobe 8'h77 arriving during ALU LO_WAIT → sent immediately after HI frame completes; no OVERRUN.
6. Assert RST low during HI_REQ → TX_D_VLD=0, TX_P_DATA=0, CTRL_BUSY=0 asynchronously; after release, no frame emitted without a new strobe.

Source files
------------

// File: rtl/sys_ctrl_pkg.sv
// Shared encodings for the transmit-side system controller.
package sys_ctrl_pkg;
  localparam int DATA_WIDTH_DEF = 8;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RD_REQ  = 3'd1;
  localparam logic [2:0] ST_RD_WAIT = 3'd2;
  localparam logic [2:0] ST_LO_REQ  = 3'd3;
  localparam logic [2:0] ST_LO_WAIT = 3'd4;
  localparam logic [2:0] ST_HI_REQ  = 3'd5;
  localparam logic [2:0] ST_HI_WAIT = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_RD_REQ  = ST_RD_REQ,
    S_RD_WAIT = ST_RD_WAIT,
    S_LO_REQ  = ST_LO_REQ,
    S_LO_WAIT = ST_LO_WAIT,
    S_HI_REQ  = ST_HI_REQ,
    S_HI_WAIT = ST_HI_WAIT
  } state_t;

  // byte lanes of the ALU result, low byte goes out first
  localparam int LO = 0;
  localparam int HI = 1;
endpackage

// File: rtl/sys_ctrl_tx_sched_slot.sv
// One-deep pending slot: holds the oldest unsent response, flags a drop when full.
module tx_pend_slot #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             vld,
  input  logic [WIDTH-1:0] din,
  input  logic             clr,
  output logic             pend,
  output logic [WIDTH-1:0] dout,
  output logic             drop
);
  // a clear in the same cycle frees the slot, so the new strobe is captured, not dropped
  assign drop = vld & pend & ~clr;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pend <= 1'b0;
      dout <= '0;
    end else if (vld && (!pend || clr)) begin
      pend <= 1'b1;
      dout <= din;
    end else if (clr) begin
      pend <= 1'b0;
    end
  end
endmodule

// File: rtl/sys_ctrl_tx_sched.sv
// Arbitrates RegFile/ALU responses and feeds them byte-wise to UART_TX over a level handshake.
module sys_ctrl_tx_sched
  import sys_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int ALU_OUT_WIDTH = 2*DATA_WIDTH
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [DATA_WIDTH-1:0]    RD_DATA,
  input  logic                     RD_DATA_VLD,
  input  logic [ALU_OUT_WIDTH-1:0] ALU_OUT,
  input  logic                     ALU_OUT_VLD,
  input  logic                     TX_BUSY,
  output logic [DATA_WIDTH-1:0]    TX_P_DATA,
  output logic                     TX_D_VLD,
  output logic                     CTRL_BUSY,
  output logic                     OVERRUN
);
  state_t                   state;
  logic                     rd_pend, alu_pend, rd_drop, alu_drop, rd_clr, alu_clr;
  logic [DATA_WIDTH-1:0]    rd_buf;
  logic [ALU_OUT_WIDTH-1:0] alu_buf, shadow;

  // slots are released on the dispatch cycle so a fresh strobe can queue behind the transfer
  assign rd_clr  = (state == S_IDLE) & ~TX_BUSY & rd_pend;
  assign alu_clr = (state == S_IDLE) & ~TX_BUSY & alu_pend & ~rd_pend;

  tx_pend_slot #(.WIDTH(DATA_WIDTH)) u_rd_slot (
    .CLK(CLK), .RST(RST), .vld(RD_DATA_VLD), .din(RD_DATA), .clr(rd_clr),
    .pend(rd_pend), .dout(rd_buf), .drop(rd_drop)
  );

  tx_pend_slot #(.WIDTH(ALU_OUT_WIDTH)) u_alu_slot (
    .CLK(CLK), .RST(RST), .vld(ALU_OUT_VLD), .din(ALU_OUT), .clr(alu_clr),
    .pend(alu_pend), .dout(alu_buf), .drop(alu_drop)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= S_IDLE;
      shadow    <= '0;
      TX_P_DATA <= '0;
      TX_D_VLD  <= 1'b0;
      CTRL_BUSY <= 1'b0;
      OVERRUN   <= 1'b0;
    end else begin
      CTRL_BUSY <= (state != S_IDLE) | rd_pend | alu_pend;
      OVERRUN   <= rd_drop | alu_drop;
      case (state)
        S_IDLE: begin
          if (rd_clr) begin
            TX_P_DATA <= rd_buf;
            TX_D_VLD  <= 1'b1;
            state     <= S_RD_REQ;
          end else if (alu_clr) begin
            shadow    <= alu_buf;
            TX_P_DATA <= alu_buf[LO*DATA_WIDTH +: DATA_WIDTH];
            TX_D_VLD  <= 1'b1;
            state     <= S_LO_REQ;
          end
        end
        S_RD_REQ: if (TX_BUSY) begin
          TX_D_VLD <= 1'b0;
          state    <= S_RD_WAIT;
        end
        S_RD_WAIT: if (!TX_BUSY) state <= S_IDLE;
        S_LO_REQ: if (TX_BUSY) begin
          TX_D_VLD <= 1'b0;
          state    <= S_LO_WAIT;
        end
        S_LO_WAIT: if (!TX_BUSY) begin
          TX_P_DATA <= shadow[HI*DATA_WIDTH +: DATA_WIDTH];
          TX_D_VLD  <= 1'b1;
          state     <= S_HI_REQ;
        end
        S_HI_REQ: if (TX_BUSY) begin
          TX_D_VLD <= 1'b0;
          state    <= S_HI_WAIT;
        end
        S_HI_WAIT: if (!TX_BUSY) state <= S_IDLE;
        default: begin
          state     <= S_IDLE;
          TX_P_DATA <= '0;
          TX_D_VLD  <= 1'b0;
          CTRL_BUSY <= 1'b0;
          OVERRUN   <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sys_ctrl_tx_sched.sv
// Bench for sys_ctrl_tx_sched: UART_TX handshake model plus an expected-frame-order model.
module tb_sys_ctrl_tx_sched;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [7:0]  RD_DATA = '0;
  logic        RD_DATA_VLD = 1'b0;
  logic [15:0] ALU_OUT = '0;
  logic        ALU_OUT_VLD = 1'b0;
  logic        TX_BUSY = 1'b0;
  logic [7:0]  TX_P_DATA;
  logic        TX_D_VLD, CTRL_BUSY, OVERRUN;

  int n_cmp = 0, n_err = 0;
  logic [7:0] got[$];
  int busy_len = 10, busy_cnt = 0, wait_cnt = 0;
  int vld_late = 0, ovr_cnt = 0;
  bit hold_busy = 1'b0;

  sys_ctrl_tx_sched #(.DATA_WIDTH(8), .ALU_OUT_WIDTH(16)) dut (
    .CLK(CLK), .RST(RST), .RD_DATA(RD_DATA), .RD_DATA_VLD(RD_DATA_VLD),
    .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD), .TX_BUSY(TX_BUSY),
    .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .CTRL_BUSY(CTRL_BUSY), .OVERRUN(OVERRUN)
  );

  always #5 CLK = ~CLK;

  // UART_TX model: accepts a byte 2 cycles after TX_D_VLD, then stays busy busy_len cycles
  always @(negedge CLK) begin
    if (!RST) begin
      TX_BUSY = 1'b0; busy_cnt = 0; wait_cnt = 0;
    end else if (hold_busy) begin
      TX_BUSY = 1'b1;
    end else if (busy_cnt > 0) begin
      if (busy_cnt == busy_len && TX_D_VLD !== 1'b0) vld_late++;
      busy_cnt--;
      if (busy_cnt == 0) TX_BUSY = 1'b0;
    end else begin
      TX_BUSY = 1'b0;
      if (TX_D_VLD === 1'b1) begin
        wait_cnt++;
        if (wait_cnt == 2) begin
          got.push_back(TX_P_DATA);
          TX_BUSY = 1'b1; busy_cnt = busy_len; wait_cnt = 0;
        end
      end else wait_cnt = 0;
    end
    if (OVERRUN === 1'b1) ovr_cnt++;
  end

  task automatic strobe(input bit do_rd, input bit do_alu, input logic [7:0] rd, input logic [15:0] alu);
    @(negedge CLK);
    RD_DATA = rd; ALU_OUT = alu; RD_DATA_VLD = do_rd; ALU_OUT_VLD = do_alu;
    @(negedge CLK);
    RD_DATA_VLD = 1'b0; ALU_OUT_VLD = 1'b0;
  endtask

  // waits for the controller and UART to both go quiet; an expired budget is a failure
  task automatic wait_idle(input string nm);
    int quiet = 0;
    repeat (3) @(negedge CLK);
    for (int i = 0; i < 3000 && quiet < 2; i++) begin
      @(negedge CLK);
      if (!CTRL_BUSY && !TX_BUSY && !TX_D_VLD && !hold_busy) quiet++; else quiet = 0;
    end
    if (quiet < 2) begin
      n_cmp++; n_err++;
      $display("FAIL %s idle_timeout: CTRL_BUSY=%b TX_BUSY=%b required quiet", nm, CTRL_BUSY, TX_BUSY);
    end
  endtask

  task automatic test_reset();
    #3 RST = 1'b0;
    #1;
    n_cmp++; if (TX_P_DATA !== 8'h00) begin n_err++; $display("FAIL reset_pdata got=%h exp=00", TX_P_DATA); end
    n_cmp++; if (TX_D_VLD !== 1'b0) begin n_err++; $display("FAIL reset_dvld got=%b exp=0", TX_D_VLD); end
    n_cmp++; if (CTRL_BUSY !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", CTRL_BUSY); end
    n_cmp++; if (OVERRUN !== 1'b0) begin n_err++; $display("FAIL reset_ovr got=%b exp=0", OVERRUN); end
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    repeat (3) @(negedge CLK);
  endtask

  task automatic test_rd_single();
    int base = got.size(), late0 = vld_late;
    strobe(1, 0, 8'h5A, '0);
    wait_idle("rd_single");
    n_cmp++; if (got.size() != base + 1) begin n_err++; $display("FAIL rd_single_count got=%0d exp=1", got.size() - base); end
    else begin
      n_cmp++; if (got[base] !== 8'h5A) begin n_err++; $display("FAIL rd_single_data got=%h exp=5a", got[base]); end
    end
    n_cmp++; if (vld_late != late0) begin n_err++; $display("FAIL rd_single_vld_drop got=%0d late exp=0", vld_late - late0); end
    n_cmp++; if (CTRL_BUSY !== 1'b0) begin n_err++; $display("FAIL rd_single_busy got=%b exp=0", CTRL_BUSY); end
  endtask

  task automatic test_alu_single();
    int base = got.size();
    logic [7:0] exp[$] = '{8'hEF, 8'hBE};
    strobe(0, 1, '0, 16'hBEEF);
    wait_idle("alu_single");
    n_cmp++; if (got.size() - base != exp.size()) begin n_err++; $display("FAIL alu_single_count got=%0d exp=%0d", got.size() - base, exp.size()); end
    else foreach (exp[i]) begin
      n_cmp++; if (got[base+i] !== exp[i]) begin n_err++; $display("FAIL alu_single_byte%0d got=%h exp=%h", i, got[base+i], exp[i]); end
    end
  endtask

  task automatic test_both_same_cycle();
    int base = got.size();
    logic [7:0] exp[$] = '{8'h11, 8'h33, 8'h22};
    strobe(1, 1, 8'h11, 16'h2233);
    wait_idle("both");
    n_cmp++; if (got.size() - base != exp.size()) begin n_err++; $display("FAIL both_count got=%0d exp=%0d", got.size() - base, exp.size()); end
    else foreach (exp[i]) begin
      n_cmp++; if (got[base+i] !== exp[i]) begin n_err++; $display("FAIL both_byte%0d got=%h exp=%h", i, got[base+i], exp[i]); end
    end
  endtask

  task automatic test_overrun();
    int base = got.size(), ovr0 = ovr_cnt;
    logic [7:0] exp[$] = '{8'h02, 8'h01};
    @(negedge CLK); hold_busy = 1'b1;
    strobe(0, 1, '0, 16'h0102);
    repeat (3) @(negedge CLK);
    strobe(0, 1, '0, 16'hAAAA);
    repeat (4) @(negedge CLK);
    n_cmp++; if (ovr_cnt - ovr0 != 1) begin n_err++; $display("FAIL overrun_pulses got=%0d exp=1", ovr_cnt - ovr0); end
    hold_busy = 1'b0;
    wait_idle("overrun");
    n_cmp++; if (got.size() - base != exp.size()) begin n_err++; $display("FAIL overrun_count got=%0d exp=%0d", got.size() - base, exp.size()); end
    else foreach (exp[i]) begin
      n_cmp++; if (got[base+i] !== exp[i]) begin n_err++; $display("FAIL overrun_byte%0d got=%h exp=%h", i, got[base+i], exp[i]); end
    end
  endtask

  task automatic test_rd_during_alu();
    int base = got.size(), ovr0 = ovr_cnt;
    logic [15:0] a = 16'($urandom);
    logic [7:0] exp[$];
    exp = '{a[7:0], a[15:8], 8'h77};
    strobe(0, 1, '0, a);
    for (int i = 0; i < 200 && got.size() < base + 1; i++) @(negedge CLK);
    repeat (3) @(negedge CLK);
    strobe(1, 0, 8'h77, '0);
    wait_idle("rd_during_alu");
    n_cmp++; if (ovr_cnt != ovr0) begin n_err++; $display("FAIL rd_during_alu_ovr got=%0d exp=0", ovr_cnt - ovr0); end
    n_cmp++; if (got.size() - base != exp.size()) begin n_err++; $display("FAIL rd_during_alu_count got=%0d exp=%0d", got.size() - base, exp.size()); end
    else foreach (exp[i]) begin
      n_cmp++; if (got[base+i] !== exp[i]) begin n_err++; $display("FAIL rd_during_alu_byte%0d got=%h exp=%h", i, got[base+i], exp[i]); end
    end
  endtask

  task automatic test_reset_mid_hi();
    int base = got.size();
    bit reached = 1'b0;
    strobe(0, 1, '0, 16'h9C3D);
    for (int i = 0; i < 200 && got.size() < base + 1; i++) @(negedge CLK);
    for (int i = 0; i < 200 && TX_BUSY; i++) @(negedge CLK);
    for (int i = 0; i < 200 && !reached; i++) begin
      if (TX_D_VLD === 1'b1) reached = 1'b1; else @(negedge CLK);
    end
    n_cmp++; if (!reached) begin n_err++; $display("FAIL reset_mid_hi_reach got=0 exp=1"); end
    #1 RST = 1'b0;
    #1;
    n_cmp++; if (TX_D_VLD !== 1'b0) begin n_err++; $display("FAIL reset_mid_dvld got=%b exp=0", TX_D_VLD); end
    n_cmp++; if (TX_P_DATA !== 8'h00) begin n_err++; $display("FAIL reset_mid_pdata got=%h exp=00", TX_P_DATA); end
    n_cmp++; if (CTRL_BUSY !== 1'b0) begin n_err++; $display("FAIL reset_mid_busy got=%b exp=0", CTRL_BUSY); end
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    repeat (40) @(negedge CLK);
    n_cmp++; if (got.size() != base + 1) begin n_err++; $display("FAIL reset_mid_frames got=%0d exp=1", got.size() - base); end
    n_cmp++; if (TX_D_VLD !== 1'b0 || CTRL_BUSY !== 1'b0) begin n_err++; $display("FAIL reset_mid_quiet got=%b%b exp=00", TX_D_VLD, CTRL_BUSY); end
  endtask

  // random responses, one burst at a time; expected order: RD byte, then ALU low, then ALU high
  task automatic test_random();
    for (int it = 0; it < 24; it++) begin
      int base = got.size(), ovr0 = ovr_cnt;
      int kind = $urandom_range(0, 2);
      logic [7:0] r = 8'($urandom);
      logic [15:0] a = 16'($urandom);
      logic [7:0] exp[$];
      busy_len = $urandom_range(1, 12);
      if (kind != 1) exp.push_back(r);
      if (kind != 0) begin exp.push_back(a[7:0]); exp.push_back(a[15:8]); end
      strobe(kind != 1, kind != 0, r, a);
      wait_idle("random");
      n_cmp++; if (ovr_cnt != ovr0) begin n_err++; $display("FAIL random%0d_ovr got=%0d exp=0", it, ovr_cnt - ovr0); end
      n_cmp++; if (got.size() - base != exp.size()) begin n_err++; $display("FAIL random%0d_count got=%0d exp=%0d", it, got.size() - base, exp.size()); end
      else foreach (exp[i]) begin
        n_cmp++; if (got[base+i] !== exp[i]) begin n_err++; $display("FAIL random%0d_byte%0d got=%h exp=%h", it, i, got[base+i], exp[i]); end
      end
    end
    busy_len = 10;
  endtask

  initial begin
    test_reset();
    test_rd_single();
    test_alu_single();
    test_both_same_cycle();
    test_overrun();
    test_rd_during_alu();
    test_reset_mid_hi();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
